// File: rtl/image_point_proc_pkg.sv
// Shared definitions for the image point-operation streamer.
// Holds the mode encodings, the controller state enum and a helper that
// derives the minimum counter width for a frame of a given pixel count.
package img_pkg;

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_NEG  = 2'd1;
   localparam logic [1:0] MODE_THR  = 2'd2;
   localparam logic [1:0] MODE_ADD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Bits needed to count 0..n_pix-1 (at least one bit).
   function automatic int addr_w_for(input int n_pix);
      return (n_pix <= 2) ? 1 : $clog2(n_pix);
   endfunction

endpackage

// File: rtl/image_point_proc_if.sv
// Pixel output stream: data with start-of-frame / last markers, valid/ready.
// Latency: none (wires only).
// Backpressure: producer holds data/sof/last stable while valid && !ready.
// Ports: out_data, out_valid, out_sof, out_last driven by master;
//        out_ready driven by slave.
interface image_point_proc_if #(
   parameter int PIX_W = 8
) ();

   logic [PIX_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sof;
   logic             out_last;

   modport master (
      output out_data, out_valid, out_sof, out_last,
      input  out_ready
   );

   modport slave (
      input  out_data, out_valid, out_sof, out_last,
      output out_ready
   );

endinterface

// File: rtl/image_point_proc_skid_fifo.sv
// Small synchronous FIFO holding processed pixels ahead of the output stream.
// Latency: a pushed word is visible at head_o the cycle after the push.
// Backpressure: pushes when full and pops when empty are ignored; the caller
//   keeps the producer within credit so neither happens in normal use.
// Ports: clk, rst (sync, active-high), push_i/push_dat_i, pop_i,
//        head_o (oldest word), empty_o, count_o (occupancy).
module img_skid_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && (cnt_q != CNT_W'(DEPTH));
   assign pop_ok  = pop_i && (cnt_q != '0);

   // Depth need not be a power of two, so pointers wrap explicitly.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy gates every read of it.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/image_point_proc.sv
// Streams one frame out of a synchronous-read BRAM, applying a per-pixel
//   point operation (pass / negate / threshold / saturating add).
// Latency: first out_valid RD_LAT+2 cycles after the accepted start, then
//   one pixel per cycle while out_ready is held high.
// Backpressure: reads are issued only while reads in flight plus FIFO
//   occupancy stay below RD_LAT+2, so any out_ready pattern is absorbed.
// Ports: clk, rst (sync, active-high); start/mode/op_param control;
//   busy/done status; mem_en/mem_addr/mem_rdata BRAM read port;
//   out_if pixel stream (data, valid, ready, sof, last).
// Optional: IMG_CHECKSUM_EN adds frame_sum, the modulo sum of all pixels
//   transferred in the current frame.
module image_point_proc
   import img_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [PIX_W-1:0]          op_param,
   output logic                      busy,
   output logic                      done,
   output logic                      mem_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [PIX_W-1:0]          mem_rdata,
`ifdef IMG_CHECKSUM_EN
   output logic [ADDR_W+PIX_W-1:0]   frame_sum,
`endif
   image_point_proc_if.master        out_if
);

   localparam int N        = IMG_W * IMG_H;
   localparam int FIFO_D   = RD_LAT + 2;
   localparam int FCNT_W   = $clog2(FIFO_D + 1);
   localparam int OCNT_W   = addr_w_for(N);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [OCNT_W-1:0] LAST_OCNT = OCNT_W'(N - 1);

   state_e              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [PIX_W-1:0]    param_q, param_d;
   logic                mem_en_q, mem_en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [RD_LAT-1:0]   vld_q, vld_d;
   logic [OCNT_W-1:0]   ocnt_q, ocnt_d;
   logic                done_q, done_d;

   logic                start_acc;
   logic                last_issue;
   logic                last_hs;
   logic [7:0]          vld_cnt;
   logic [7:0]          outstanding;

   logic [PIX_W-1:0]    pix_proc;
   logic [PIX_W:0]      pix_sum;
   logic                push;
   logic                pop;
   logic [PIX_W-1:0]    fifo_head;
   logic                fifo_empty;
   logic [FCNT_W-1:0]   fifo_cnt;

   assign start_acc  = (state_q == ST_IDLE) && start;
   assign last_issue = mem_en_q && (addr_q == LAST_ADDR);
   assign pop        = !fifo_empty && out_if.out_ready;
   assign last_hs    = pop && (ocnt_q == LAST_OCNT);

   // Credit: the read on the bus now, reads in the delay line and queued
   // pixels all need a FIFO slot; a pop this cycle frees one. Deciding on
   // the post-edge total keeps full throughput with the registered mem_en.
   always_comb begin
      vld_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         vld_cnt = vld_cnt + 8'(vld_q[i]);
      end
      outstanding = 8'(mem_en_q) + vld_cnt + 8'(fifo_cnt) - 8'(pop);
   end

   // Valid tag for each issued read; the top stage lines up with mem_rdata.
   assign vld_d = (vld_q << 1) | RD_LAT'(mem_en_q);
   assign push  = vld_q[RD_LAT-1];

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      param_d  = param_q;
      addr_d   = addr_q;
      mem_en_d = 1'b0;
      ocnt_d   = ocnt_q;
      done_d   = 1'b0;

      if (pop) begin
         ocnt_d = ocnt_q + OCNT_W'(1);
      end
      if (mem_en_q && !last_issue) begin
         addr_d = addr_q + ADDR_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               mode_d  = mode;
               param_d = op_param;
            end
         end
         ST_RUN: begin
            if (last_issue) begin
               state_d = ST_DRAIN;
            end else begin
               mem_en_d = (outstanding < 8'(FIFO_D));
            end
         end
         ST_DRAIN: begin
            if (last_hs) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               addr_d  = '0;
               ocnt_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_PASS;
         param_q  <= '0;
         mem_en_q <= 1'b0;
         addr_q   <= '0;
         vld_q    <= '0;
         ocnt_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         param_q  <= param_d;
         mem_en_q <= mem_en_d;
         addr_q   <= addr_d;
         vld_q    <= vld_d;
         ocnt_q   <= ocnt_d;
         done_q   <= done_d;
      end
   end

   // Point operation on the returning BRAM word, using the latched mode.
   assign pix_sum = {1'b0, mem_rdata} + {1'b0, param_q};

   always_comb begin
      pix_proc = mem_rdata;
      case (mode_q)
         MODE_PASS: pix_proc = mem_rdata;
         MODE_NEG:  pix_proc = ~mem_rdata;  // equals max - p
         MODE_THR:  pix_proc = (mem_rdata >= param_q) ? '1 : '0;
         MODE_ADD:  pix_proc = pix_sum[PIX_W] ? '1 : pix_sum[PIX_W-1:0];
         default:   pix_proc = mem_rdata;
      endcase
   end

   img_skid_fifo #(
      .WIDTH (PIX_W),
      .DEPTH (FIFO_D)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (pix_proc),
      .pop_i      (pop),
      .head_o     (fifo_head),
      .empty_o    (fifo_empty),
      .count_o    (fifo_cnt)
   );

   // Head and output count only move on a pop, so a stalled pixel and its
   // markers stay put.
   assign out_if.out_valid = !fifo_empty;
   assign out_if.out_data  = fifo_empty ? '0 : fifo_head;
   assign out_if.out_sof   = !fifo_empty && (ocnt_q == '0);
   assign out_if.out_last  = !fifo_empty && (ocnt_q == LAST_OCNT);

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign mem_en   = mem_en_q;
   assign mem_addr = addr_q;

`ifdef IMG_CHECKSUM_EN
   localparam int SUM_W = ADDR_W + PIX_W;
   logic [SUM_W-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         sum_q <= '0;
      end else if (pop) begin
         sum_q <= sum_q + SUM_W'(fifo_head);
      end
   end

   assign frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_image_point_proc.sv
// Directed bench for image_point_proc with a behavioural BRAM and a
//   scoreboard of expected pixels filled when each frame is started.
// Latency/backpressure are checked against the stream as observed.
module tb_image_point_proc;

   localparam int PIX_W  = 8;
   localparam int IMG_W  = 32;
   localparam int IMG_H  = 32;
   localparam int ADDR_W = 16;
   localparam int RD_LAT = 2;
   localparam int N      = IMG_W * IMG_H;

   typedef struct packed {
      logic [PIX_W-1:0] d;
      logic             sof;
      logic             last;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [1:0]         mode;
   logic [PIX_W-1:0]   op_param;
   logic               busy;
   logic               done;
   logic               mem_en;
   logic [ADDR_W-1:0]  mem_addr;
   logic [PIX_W-1:0]   mem_rdata;
`ifdef IMG_CHECKSUM_EN
   logic [ADDR_W+PIX_W-1:0] frame_sum;
`endif

   image_point_proc_if #(.PIX_W(PIX_W)) out_if ();

   image_point_proc #(
      .PIX_W (PIX_W), .IMG_W (IMG_W), .IMG_H (IMG_H),
      .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .op_param  (op_param),
      .busy      (busy),
      .done      (done),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
`ifdef IMG_CHECKSUM_EN
      .frame_sum (frame_sum),
`endif
      .out_if    (out_if)
   );

   always #5 clk = ~clk;

   // Behavioural BRAM: data appears RD_LAT cycles after the read enable.
   logic [PIX_W-1:0] bram    [N];
   logic [PIX_W-1:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (mem_en) rd_pipe[0] <= bram[mem_addr[9:0]];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   logic [PIX_W-1:0] obs [N];
   int   issued = 0;
   int   xfer = 0;
   int   done_cnt = 0;
   bit   rand_rdy = 0;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   function automatic logic [7:0] ref_op(input logic [1:0] m, input logic [7:0] p,
                                         input logic [7:0] prm);
      int s;
      case (m)
         2'd0:    return p;
         2'd1:    return 8'(255 - int'(p));
         2'd2:    return (p >= prm) ? 8'd255 : 8'd0;
         default: begin
            s = int'(p) + int'(prm);
            return (s > 255) ? 8'd255 : 8'(s);
         end
      endcase
   endfunction

   // Downstream ready: always high, or a coin flip per cycle.
   initial begin
      out_if.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 out_if.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output / read-port monitor.
   logic             prev_stall = 1'b0;
   logic             prev_hs_last = 1'b0;
   logic [PIX_W-1:0] prev_d;
   logic             prev_sof, prev_last;
   exp_t             e;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         issued = 0;
         xfer = 0;
         prev_stall = 1'b0;
         prev_hs_last = 1'b0;
      end else begin
         if (mem_en) begin
            chk("read_credit", 32'((issued - xfer) < RD_LAT + 2), 32'd1);
            chk("read_addr", 32'(mem_addr), 32'(issued));
            issued++;
         end
         if (prev_stall) begin
            chk("stall_valid", 32'(out_if.out_valid), 32'd1);
            chk("stall_data", 32'(out_if.out_data), 32'(prev_d));
            chk("stall_sof", 32'(out_if.out_sof), 32'(prev_sof));
            chk("stall_last", 32'(out_if.out_last), 32'(prev_last));
         end
         chk("done_timing", 32'(done), 32'(prev_hs_last));
         prev_hs_last = 1'b0;
         if (out_if.out_valid && out_if.out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("pix_data", 32'(out_if.out_data), 32'(e.d));
               chk("pix_sof", 32'(out_if.out_sof), 32'(e.sof));
               chk("pix_last", 32'(out_if.out_last), 32'(e.last));
            end
            if (xfer < N) obs[xfer] = out_if.out_data;
            prev_hs_last = out_if.out_last;
            xfer++;
         end
         prev_stall = out_if.out_valid && !out_if.out_ready;
         prev_d     = out_if.out_data;
         prev_sof   = out_if.out_sof;
         prev_last  = out_if.out_last;
         if (done) begin
            done_cnt++;
            chk("done_count", 32'(xfer), 32'(N));
            chk("done_sb_empty", 32'(sb.size()), 32'd0);
            issued = 0;
            xfer = 0;
         end
      end
   end

   // Called at a negedge: queue expectations, then pulse start for one edge.
   task automatic start_frame(input logic [1:0] m, input logic [7:0] prm);
      #1;
      for (int i = 0; i < N; i++) begin
         sb.push_back('{d: ref_op(m, bram[i], prm), sof: (i == 0), last: (i == N - 1)});
      end
      start = 1'b1;
      mode = m;
      op_param = prm;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int first_vld, output int gaps);
      bit seen = 0;
      bit got = 0;
      first_vld = -1;
      gaps = 0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (k == 0) chk("busy_after_start", 32'(busy), 32'd1);
         if (done) begin
            got = 1;
            chk("busy_with_done", 32'(busy), 32'd0);
            break;
         end
         if (out_if.out_valid && first_vld < 0) first_vld = k;
         if (out_if.out_valid) seen = 1;
         else if (seen) gaps++;
      end
      chk("done_seen", 32'(got), 32'd1);
   endtask

   int first_vld, gaps, done_before;

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0; op_param = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_valid", 32'(out_if.out_valid), 32'd0);
      chk("rst_sof", 32'(out_if.out_sof), 32'd0);
      chk("rst_last", 32'(out_if.out_last), 32'd0);
      chk("rst_data", 32'(out_if.out_data), 32'd0);
`ifdef IMG_CHECKSUM_EN
      chk("rst_sum", 32'(frame_sum), 32'd0);
`endif
      #1 rst = 1'b0;
      @(negedge clk);

      // Negate over addr[7:0], full throughput.
      for (int i = 0; i < N; i++) bram[i] = 8'(i);
      start_frame(2'd1, 8'd0);
      wait_done(5000, first_vld, gaps);
      chk("first_valid_latency", 32'(first_vld), 32'(RD_LAT + 2));
      chk("stream_gaps", 32'(gaps), 32'd0);
      chk("neg_pix0", 32'(obs[0]), 32'd255);
      chk("neg_pix1023", 32'(obs[1023]), 32'd0);

      // Saturating add, +200; a second start mid-frame must be ignored.
      bram[0] = 8'd100;
      bram[1] = 8'd40;
      start_frame(2'd3, 8'd200);          // issued in the done cycle
      repeat (100) @(negedge clk);
      #1 start = 1'b1; mode = 2'd0; op_param = 8'd0;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(5000, first_vld, gaps);
      chk("add_sat", 32'(obs[0]), 32'd255);
      chk("add_nosat", 32'(obs[1]), 32'd240);

      // Threshold at 128.
      bram[0] = 8'd127;
      bram[1] = 8'd128;
      start_frame(2'd2, 8'd128);
      wait_done(5000, first_vld, gaps);
      chk("thr_below", 32'(obs[0]), 32'd0);
      chk("thr_at", 32'(obs[1]), 32'd255);

      // Pass-through of random data with random downstream stalls.
      for (int i = 0; i < N; i++) bram[i] = 8'($urandom);
      rand_rdy = 1;
      start_frame(2'd0, 8'd0);
      wait_done(8000, first_vld, gaps);
      rand_rdy = 0;

      // Abort mid-frame with reset, then restart from address 0.
      for (int i = 0; i < N; i++) bram[i] = 8'(i);
      repeat (2) @(negedge clk);
      start_frame(2'd0, 8'd0);
      for (int k = 0; k < 3000 && xfer < 500; k++) @(negedge clk);
      chk("abort_point", 32'(xfer), 32'd500);
      done_before = done_cnt;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'(done_before));
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(out_if.out_valid), 32'd0);
      start_frame(2'd0, 8'd0);
      wait_done(5000, first_vld, gaps);
      chk("restart_latency", 32'(first_vld), 32'(RD_LAT + 2));
      chk("restart_pix0", 32'(obs[0]), 32'd0);
`ifdef IMG_CHECKSUM_EN
      chk("frame_sum", 32'(frame_sum), 32'd130560);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
